ttt_nxn_engine: RTL and testbench
=================================

Name: ttt_nxn_engine

Overview:
- Parametrised successor of the 3x3 tic-tac-toe game core, for an NxN board where a win is a complete row, column or diagonal.
- Owns the board registers, the turn FSM, move legality checking and a sequential win/draw scanner.
- Sits between the move source (player input or computer-move logic) and the board display/LED driver.
- Cell encoding shared with the display path: 00 empty, 01 player A (X), 10 player B (O).

Parameters:
- N, 3, board side; legal range 3..8; board holds N*N cells.
- TIMEOUT_CYCLES, 1000, idle cycles allowed per move; used only when MOVE_TIMEOUT_EN is defined.
- Derived constant: PW = clog2(N*N), the position index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; clears the board and begins a new game, player A to move.
- move_valid  in  1  a move is offered.
- move_ready  out  1  the engine can accept a move.
- move_player  in  1  mover identity: 0 = A, 1 = B.
- move_pos  in  PW  cell index, row-major; index = row*N + col.
- board  out  2*N*N  cell i occupies bits [2i+1:2i].
- turn  out  1  player expected to move next.
- move_reject  out  1  one-cycle pulse on a rejected handshake.
- reject_code  out  2  01 = not your turn, 10 = out of range, 11 = occupied; held until the next handshake.
- game_over  out  1  high while in OVER.
- winner  out  2  00 none, 01 A, 10 B.
- draw  out  1  board full with no winner.
- timeout  out  1  the game ended on a move timeout.

Behaviour:
- Reset: all outputs and the board are 0; state IDLE; turn = 0; move count = 0.
- States:
  - IDLE: waits for start.
  - START: wait-for-move state (WAIT_MOVE) entered after a start pulse.
  - CHECK: scans for a win.
  - OVER: game finished.
- start:
  - Accepted in every state.
  - Next edge: board cleared, winner/draw/timeout/reject_code cleared, turn = A, count = 0, state = WAIT_MOVE.
  - A start during CHECK aborts the scan.
- move_ready = (state == WAIT_MOVE) && !start. A handshake is move_valid && move_ready. start has priority over a same-cycle move.
- Legality, checked in this priority order: wrong player (01), then move_pos >= N*N (10), then cell occupied (11).
- Illegal handshake:
  - move_reject pulses for one cycle and reject_code is updated.
  - Board and turn are unchanged; state stays WAIT_MOVE.
- Legal handshake at edge T:
  - At edge T the cell is written, the count is incremented, reject_code is set to 00 and state = CHECK.
- CHECK:
  - Evaluates one line per cycle, line index 0..2N+1: rows 0..N-1, then columns, then the main diagonal (2N), then the anti-diagonal (2N+1).
  - A line wins when all N cells are equal and non-empty.
  - On the first winning line: winner = that cell value and state = OVER on the next edge (early exit).
  - After line 2N+1 with no win:
    - If count == N*N: draw = 1 and state = OVER.
    - Otherwise: turn toggles and state = WAIT_MOVE.
  - With no win, move_ready returns at edge T+2N+2 (edge T+8 for N=3).
- OVER:
  - game_over = 1 and move_ready = 0.
  - move_valid is ignored, with no reject.
  - Only start or reset leaves this state.
- move_count width is clog2(N*N+1); the count never exceeds N*N.
- Reset asserted mid-game clears everything immediately.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A counter runs only in WAIT_MOVE; it is cleared on entering WAIT_MOVE and on any handshake, legal or rejected.
  - When the counter reaches TIMEOUT_CYCLES: the next edge sets state = OVER, timeout = 1 and winner = the opponent of turn.
- Undefined: no counter is built; the timeout port is tied to 0.

Decomposition:
- Package ttt_pkg holds:
  - cell encodings CELL_EMPTY/CELL_A/CELL_B;
  - the state enum (IDLE, WAIT_MOVE, CHECK, OVER);
  - the reject codes REJ_NONE/REJ_TURN/REJ_RANGE/REJ_OCC.
- Sub-module ttt_line_select:
  - Combinational.
  - Given the board and a line index, returns the line's N cells and a win/owner result.
  - The engine instantiates it once, driven by the scan counter.

Test Plan:
- N=3; A plays 0, B 3, A 1, B 4, A 2 -> after the last handshake, OVER within 1 cycle (row 0 found first); winner = 01, game_over = 1, move_ready = 0.
- N=3; A plays 4, then B plays 4 -> move_reject pulse, reject_code = 11, board[9:8] = 01, turn stays 1; then B plays pos 9 -> reject_code = 10; then A offers pos 0 -> reject_code = 01.
- N=3 draw sequence A0 B1 A2 B4 A3 B5 A7 B6 A8 -> draw = 1, winner = 00, OVER reached 8 cycles after the last handshake.
- N=4, B completes anti-diagonal 3, 6, 9, 12 -> winner = 10 detected on scan line 9; move_ready stays low.
- start pulsed mid-CHECK -> board = 0, turn = 0, WAIT_MOVE next cycle. Reset asserted mid-WAIT_MOVE -> all outputs 0 asynchronously.
- MOVE_TIMEOUT_EN defined, TIMEOUT_CYCLES = 20, A idle for 20 cycles after start -> timeout = 1, winner = 10, game_over = 1.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the NxN tic-tac-toe engine.
//   - Cell encodings, which are shared with the board display path.
//   - The engine state enum.
//   - Reject codes reported on move_reject / reject_code.
//   - mover_cell(): maps a player bit to that player's cell value.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_A     = 2'b01;  // player A, X
  localparam logic [1:0] CELL_B     = 2'b10;  // player B, O

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    CHECK     = 2'd2,
    OVER      = 2'd3
  } state_e;

  localparam logic [1:0] REJ_NONE  = 2'b00;
  localparam logic [1:0] REJ_TURN  = 2'b01;
  localparam logic [1:0] REJ_RANGE = 2'b10;
  localparam logic [1:0] REJ_OCC   = 2'b11;

  // Cell value written when the given player moves (0 = A, 1 = B).
  function automatic logic [1:0] mover_cell(input logic player);
    return player ? CELL_B : CELL_A;
  endfunction

endpackage

// File: rtl/ttt_line_select.sv
// ttt_line_select: combinational line extractor for an NxN board.
//
// Line numbering:
//   0 .. N-1  rows
//   N .. 2N-1 columns
//   2N        main diagonal
//   2N+1      anti-diagonal
// A line wins when all N of its cells hold the same non-empty value.
//
// Ports:
//   board_i  in  2*N*N  flattened board; cell i occupies bits [2i+1:2i]
//   line_i   in  LW     line index, 0 .. 2N+1
//   cells_o  out 2*N    the line's cells; cell k of the line occupies bits [2k+1:2k]
//   win_o    out 1      the selected line is complete for one player
//   owner_o  out 2      winning cell value when win_o, otherwise CELL_EMPTY
module ttt_line_select
  import ttt_pkg::*;
#(
  parameter  int N  = 3,
  localparam int LW = $clog2(2*N+2),
  localparam int PW = $clog2(N*N)
)(
  input  logic [2*N*N-1:0] board_i,
  input  logic [LW-1:0]    line_i,
  output logic [2*N-1:0]   cells_o,
  output logic             win_o,
  output logic [1:0]       owner_o
);

  logic [1:0]   cell_arr   [N*N];
  logic [1:0]   line_cells [N];
  logic [N-1:0] match;

  // Board position of the k-th cell of a line. Codes above 2N+1 never
  // occur during a scan; they alias the anti-diagonal.
  function automatic logic [PW-1:0] cell_index(input logic [LW-1:0] line, input int k);
    int l;
    int idx;
    l = int'(line);
    if (l < N)           idx = l * N + k;
    else if (l < 2 * N)  idx = k * N + (l - N);
    else if (l == 2 * N) idx = k * N + k;
    else                 idx = k * N + (N - 1 - k);
    return PW'(idx);
  endfunction

  for (genvar gi = 0; gi < N * N; gi++) begin : g_unpack
    assign cell_arr[gi] = board_i[2*gi +: 2];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    assign line_cells[gi]   = cell_arr[cell_index(line_i, gi)];
    assign cells_o[2*gi +: 2] = line_cells[gi];
    assign match[gi]        = (line_cells[gi] == line_cells[0]);
  end

  assign win_o   = (&match) && (line_cells[0] != CELL_EMPTY);
  assign owner_o = win_o ? line_cells[0] : CELL_EMPTY;

endmodule

// File: rtl/ttt_nxn_engine.sv
// ttt_nxn_engine: NxN tic-tac-toe game core.
//   Holds the board, runs the turn FSM, checks move legality and scans
//   one line per cycle for a win after every legal move.
//
// Build option: define MOVE_TIMEOUT_EN to add the per-move idle timeout.
// Without it no timeout counter exists and the timeout output is 0.
//
// Ports:
//   clk          in  1      clock
//   reset        in  1      asynchronous active-high reset
//   start        in  1      pulse: clear the board, new game, A to move
//   move_valid   in  1      a move is offered
//   move_ready   out 1      engine accepts a move this cycle
//   move_player  in  1      mover: 0 = A, 1 = B
//   move_pos     in  PW     cell index, row*N + col
//   board        out 2*N*N  cell i at bits [2i+1:2i]
//   turn         out 1      player expected to move next
//   move_reject  out 1      one-cycle pulse after a rejected handshake
//   reject_code  out 2      reason of the last rejection, 00 after a legal move
//   game_over    out 1      high while the game is finished
//   winner       out 2      00 none, 01 A, 10 B
//   draw         out 1      board full with no winner
//   timeout      out 1      game ended on a move timeout
module ttt_nxn_engine
  import ttt_pkg::*;
#(
  parameter  int N              = 3,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int PW             = $clog2(N*N)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic             move_player,
  input  logic [PW-1:0]    move_pos,
  output logic [2*N*N-1:0] board,
  output logic             turn,
  output logic             move_reject,
  output logic [1:0]       reject_code,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             draw,
  output logic             timeout
);

  localparam int CELLS = N * N;
  localparam int CW    = $clog2(CELLS + 1);
  localparam int LW    = $clog2(2 * N + 2);

  localparam logic [CW-1:0] FULL_COUNT = CW'(CELLS);
  localparam logic [LW-1:0] LAST_LINE  = LW'(2 * N + 1);
  localparam logic [PW:0]   CELLS_EXT  = (PW+1)'(CELLS);

  state_e          state_q, state_d;
  logic [1:0]      cells_q [CELLS];
  logic [1:0]      cells_d [CELLS];
  logic            turn_q, turn_d;
  logic [CW-1:0]   count_q, count_d;
  logic [LW-1:0]   scan_q, scan_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;
  logic [1:0]      rej_code_q, rej_code_d;
  logic            rej_pulse_q, rej_pulse_d;

  logic            handshake;
  logic            line_win;
  logic [1:0]      line_owner;
  logic [2*N-1:0]  line_cells;

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;
`endif

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_board
    assign board[2*gi +: 2] = cells_q[gi];
  end

  ttt_line_select #(.N(N)) u_line_select (
    .board_i (board),
    .line_i  (scan_q),
    .cells_o (line_cells),
    .win_o   (line_win),
    .owner_o (line_owner)
  );

  // start wins over a move offered in the same cycle.
  assign move_ready  = (state_q == WAIT_MOVE) && !start;
  assign handshake   = move_valid && move_ready;
  assign turn        = turn_q;
  assign move_reject = rej_pulse_q;
  assign reject_code = rej_code_q;
  assign game_over   = (state_q == OVER);
  assign winner      = winner_q;
  assign draw        = draw_q;
`ifdef MOVE_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    turn_d      = turn_q;
    count_d     = count_q;
    scan_d      = scan_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
    rej_code_d  = rej_code_q;
    rej_pulse_d = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    timeout_d   = timeout_q;
`endif
    if (start) begin
      for (int i = 0; i < CELLS; i++) cells_d[i] = CELL_EMPTY;
      turn_d     = 1'b0;
      count_d    = '0;
      scan_d     = '0;
      winner_d   = CELL_EMPTY;
      draw_d     = 1'b0;
      rej_code_d = REJ_NONE;
      state_d    = WAIT_MOVE;
`ifdef MOVE_TIMEOUT_EN
      tcnt_d     = '0;
      timeout_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        WAIT_MOVE: begin
          if (handshake) begin
`ifdef MOVE_TIMEOUT_EN
            tcnt_d = '0;
`endif
            if (move_player != turn_q) begin
              rej_pulse_d = 1'b1;
              rej_code_d  = REJ_TURN;
            end else if ({1'b0, move_pos} >= CELLS_EXT) begin
              rej_pulse_d = 1'b1;
              rej_code_d  = REJ_RANGE;
            end else if (cells_q[move_pos] != CELL_EMPTY) begin
              rej_pulse_d = 1'b1;
              rej_code_d  = REJ_OCC;
            end else begin
              cells_d[move_pos] = mover_cell(turn_q);
              count_d    = count_q + 1'b1;
              rej_code_d = REJ_NONE;
              scan_d     = '0;
              state_d    = CHECK;
            end
          end
`ifdef MOVE_TIMEOUT_EN
          else if (tcnt_q == TIMEOUT_LIMIT) begin
            // The idle player forfeits: the opponent is declared winner.
            state_d   = OVER;
            timeout_d = 1'b1;
            winner_d  = turn_q ? CELL_A : CELL_B;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
`endif
        end
        CHECK: begin
          if (line_win) begin
            winner_d = line_owner;
            state_d  = OVER;
          end else if (scan_q == LAST_LINE) begin
            if (count_q == FULL_COUNT) begin
              draw_d  = 1'b1;
              state_d = OVER;
            end else begin
              turn_d  = ~turn_q;
              state_d = WAIT_MOVE;
`ifdef MOVE_TIMEOUT_EN
              tcnt_d  = '0;
`endif
            end
          end else begin
            scan_d = scan_q + 1'b1;
          end
        end
        default: ;  // IDLE and OVER are left only through start or reset
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < CELLS; i++) cells_q[i] <= CELL_EMPTY;
      turn_q      <= 1'b0;
      count_q     <= '0;
      scan_q      <= '0;
      winner_q    <= CELL_EMPTY;
      draw_q      <= 1'b0;
      rej_code_q  <= REJ_NONE;
      rej_pulse_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cells_q     <= cells_d;
      turn_q      <= turn_d;
      count_q     <= count_d;
      scan_q      <= scan_d;
      winner_q    <= winner_d;
      draw_q      <= draw_d;
      rej_code_q  <= rej_code_d;
      rej_pulse_q <= rej_pulse_d;
`ifdef MOVE_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ttt_nxn_engine.sv
// tb_ttt_nxn_engine: self-checking bench for ttt_nxn_engine.
// Two engines (N=3 and N=4) share the stimulus; sel_n picks the one whose
// outputs are compared against the game model kept in this bench.
module tb_ttt_nxn_engine;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_player = 1'b0;
  logic [3:0] move_pos = 4'd0;

  logic        ready3, turn3, rej3, over3, draw3, tmo3;
  logic [1:0]  code3, win3;
  logic [17:0] board3;
  logic        ready4, turn4, rej4, over4, draw4, tmo4;
  logic [1:0]  code4, win4;
  logic [31:0] board4;

  ttt_nxn_engine #(.N(3), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move_ready(ready3), .move_player(move_player), .move_pos(move_pos),
    .board(board3), .turn(turn3), .move_reject(rej3), .reject_code(code3),
    .game_over(over3), .winner(win3), .draw(draw3), .timeout(tmo3)
  );

  ttt_nxn_engine #(.N(4), .TIMEOUT_CYCLES(TMO)) dut4 (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move_ready(ready4), .move_player(move_player), .move_pos(move_pos),
    .board(board4), .turn(turn4), .move_reject(rej4), .reject_code(code4),
    .game_over(over4), .winner(win4), .draw(draw4), .timeout(tmo4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel_n = 3;

  logic        o_ready, o_turn, o_rej, o_over, o_draw, o_tmo;
  logic [1:0]  o_code, o_win;
  logic [63:0] o_board;

  always_comb begin
    if (sel_n == 4) begin
      o_ready = ready4; o_turn = turn4; o_rej = rej4; o_over = over4;
      o_draw = draw4; o_tmo = tmo4; o_code = code4; o_win = win4;
      o_board = 64'(board4);
    end else begin
      o_ready = ready3; o_turn = turn3; o_rej = rej3; o_over = over3;
      o_draw = draw3; o_tmo = tmo3; o_code = code3; o_win = win3;
      o_board = 64'(board3);
    end
  end

  // ---------------- reference game model ----------------
  int m_n;
  int m_board [64];
  int m_turn, m_count, m_winner, m_over, m_draw, m_rej, m_tmo, m_active;

  function automatic void m_reset();
    m_n = sel_n;
    for (int i = 0; i < 64; i++) m_board[i] = 0;
    m_turn = 0; m_count = 0; m_winner = 0; m_over = 0;
    m_draw = 0; m_rej = 0; m_tmo = 0; m_active = 0;
  endfunction

  function automatic void m_new_game();
    m_reset();
    m_active = 1;
  endfunction

  function automatic logic [63:0] m_packed();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < m_n * m_n; i++) v[2*i +: 2] = 2'(m_board[i]);
    return v;
  endfunction

  // Board cell of the k-th element of line l (rows, columns, diag, anti-diag).
  function automatic int line_pos(input int l, input int k);
    if (l < m_n)      return l * m_n + k;
    if (l < 2 * m_n)  return k * m_n + (l - m_n);
    if (l == 2 * m_n) return k * (m_n + 1);
    return (k + 1) * (m_n - 1);
  endfunction

  function automatic int m_first_win();
    int first;
    bit same;
    for (int l = 0; l < 2 * m_n + 2; l++) begin
      first = m_board[line_pos(l, 0)];
      same = 1'b1;
      for (int k = 1; k < m_n; k++)
        if (m_board[line_pos(l, k)] != first) same = 1'b0;
      if (same && first != 0) return l;
    end
    return -1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ":board"},  o_board, m_packed());
    chk({t, ":turn"},   64'(o_turn), 64'(m_turn));
    chk({t, ":winner"}, 64'(o_win), 64'(m_winner));
    chk({t, ":draw"},   64'(o_draw), 64'(m_draw));
    chk({t, ":over"},   64'(o_over), 64'(m_over));
    chk({t, ":code"},   64'(o_code), 64'(m_rej));
    chk({t, ":ready"},  64'(o_ready), 64'(m_active != 0 && m_over == 0));
    chk({t, ":timeout"}, 64'(o_tmo), 64'(m_tmo));
  endtask

  task automatic do_start(input bit with_move);
    start = 1'b1;
    if (with_move) begin
      move_valid = 1'b1; move_player = 1'b0; move_pos = 4'd0;
    end
    #2;
    chk("ready_during_start", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    move_valid = 1'b0;
    m_new_game();
    #1;
    check_all("start");
  endtask

  // Offer one move and follow it until the engine is ready again or over.
  task automatic play(input int p, input int q);
    int code, line, exp_cyc, cyc;
    move_player = p[0];
    move_pos = q[3:0];
    if (m_over != 0) begin
      move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      chk("over_no_reject", 64'(o_rej), 64'd0);
      check_all("over_ignore");
      return;
    end
    chk("ready_pre", 64'(o_ready), 64'd1);
    if (p != m_turn)                code = 1;
    else if (q >= m_n * m_n)        code = 2;
    else if (m_board[q] != 0)       code = 3;
    else                            code = 0;
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    if (code != 0) begin
      m_rej = code;
      chk("reject_pulse", 64'(o_rej), 64'd1);
      check_all("reject");
      @(posedge clk); #1;
      chk("reject_pulse_end", 64'(o_rej), 64'd0);
    end else begin
      m_board[q] = p + 1;
      m_count++;
      m_rej = 0;
      chk("accept_no_reject", 64'(o_rej), 64'd0);
      chk("check_not_ready", 64'(o_ready), 64'd0);
      chk("accept_board", o_board, m_packed());
      chk("accept_code", 64'(o_code), 64'd0);
      line = m_first_win();
      exp_cyc = (line >= 0) ? line + 1 : 2 * m_n + 2;
      cyc = 0;
      while (cyc < 3 * m_n + 6) begin
        @(posedge clk); #1;
        cyc++;
        if (o_over || o_ready) break;
      end
      chk("scan_cycles", 64'(cyc), 64'(exp_cyc));
      if (line >= 0) begin
        m_over = 1;
        m_winner = m_board[line_pos(line, 0)];
      end else if (m_count == m_n * m_n) begin
        m_over = 1;
        m_draw = 1;
      end else begin
        m_turn = 1 - m_turn;
      end
      check_all("after_move");
    end
    $display("[%0t] N=%0d move p=%0d pos=%0d code=%0d over=%0d winner=%0d draw=%0d",
             $time, m_n, p, q, code, m_over, m_winner, m_draw);
  endtask

  task automatic random_games(input int games);
    int p, q;
    for (int g = 0; g < games; g++) begin
      do_start(1'b0);
      for (int m = 0; m < 60 && m_over == 0; m++) begin
        p = ($urandom_range(0, 4) == 0) ? 1 - m_turn : m_turn;
        q = $urandom_range(0, (m_n == 3) ? 11 : 15);
        play(p, q);
      end
      play(m_turn, 0);  // offered while over (or still running)
    end
  endtask

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int anti_seq [8] = '{0, 3, 1, 6, 2, 9, 4, 12};
  int cyc;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    sel_n = 3;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_reject", 64'(o_rej), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("idle");

    // Row 0 win for A, detected on the first scan line.
    do_start(1'b0);
    play(0, 0); play(1, 3); play(0, 1); play(1, 4); play(0, 2);
    play(1, 5);

    // Rejections: occupied, out of range, wrong player.
    do_start(1'b0);
    play(0, 4); play(1, 4); play(1, 9); play(0, 0);

    // Full board, no winner.
    do_start(1'b0);
    for (int i = 0; i < 9; i++) play(i % 2, draw_seq[i]);
    play(0, 0);

    // start beats a move offered in the same cycle.
    do_start(1'b0);
    do_start(1'b1);

    // start during CHECK aborts the scan.
    move_player = 1'b0; move_pos = 4'd0; move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_check_not_ready", 64'(o_ready), 64'd0);
    do_start(1'b0);

    // Asynchronous reset in WAIT_MOVE.
    play(0, 4);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    check_all("async_reset");
    chk("async_reset_reject", 64'(o_rej), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle player: timeout when built in, nothing otherwise.
    do_start(1'b0);
    cyc = 0;
    while (cyc < 3 * TMO) begin
      @(posedge clk); #1;
      cyc++;
      if (o_over) break;
    end
`ifdef MOVE_TIMEOUT_EN
    chk("timeout_cycles", 64'(cyc), 64'(TMO + 1));
    m_over = 1; m_tmo = 1; m_winner = 2;
`else
    chk("no_timeout_cycles", 64'(cyc), 64'(3 * TMO));
`endif
    check_all("idle_player");
    $display("[%0t] N=3 idle for %0d cycles over=%0d timeout=%0d", $time, cyc, o_over, o_tmo);

    random_games(25);

    // N=4: B completes the anti-diagonal, found on scan line 9.
    sel_n = 4;
    do_start(1'b0);
    for (int i = 0; i < 8; i++) play(i % 2, anti_seq[i]);
    chk("n4_winner_b", 64'(o_win), 64'd2);
    play(0, 15);
    random_games(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
